// File: rtl/mem_rotate_reader.sv
// Streams a bit-rotated copy of a DEPTH x WIDTH polynomial memory, one word per cycle.
// Adjacent words k and k+1 are fetched together and funnel-shifted into a 4-entry output FIFO.
module mem_rotate_reader #(
  parameter int unsigned WIDTH   = 512,
  parameter int unsigned DEPTH   = 70,
  parameter int unsigned SHIFT_W = $clog2(DEPTH * WIDTH),
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [SHIFT_W-1:0] shift,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AW-1:0]      rd_addr_0,
  output logic [AW-1:0]      rd_addr_1,
  input  logic [WIDTH-1:0]   rd_data_0,
  input  logic [WIDTH-1:0]   rd_data_1,
  output logic [WIDTH-1:0]   out_data,
  output logic [AW-1:0]      out_index,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned Total = DEPTH * WIDTH;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    o_q, o_d;
  logic [AW-1:0]    addr0_q, addr0_d, addr1_q, addr1_d;
  logic [AW-1:0]    issue_idx_q, issue_idx_d;
  logic [AW-1:0]    push_idx_q, push_idx_d;
  logic             inflight_q, issue;
  logic             err_q, err_d;

  logic [WIDTH-1:0] fifo_data_q [4];
  logic [AW-1:0]    fifo_idx_q  [4];
  logic             fifo_last_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       fifo_cnt_q, fifo_cnt_d;

  logic             too_big, push, pop;
  logic [AW-1:0]    start_k;
  logic [WIDTH-1:0] push_data;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] k);
    return (k == LastIdx) ? '0 : k + 1'b1;
  endfunction

  assign too_big   = ({1'b0, shift} >= (SHIFT_W + 1)'(Total));
  assign start_k   = AW'(shift >> OW);
  // Low WIDTH bits of the shifted pair {word k+1, word k} form the rotated word.
  assign push_data = WIDTH'({rd_data_1, rd_data_0} >> o_q);
  assign push      = inflight_q;

  assign out_valid = (fifo_cnt_q != 3'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_index = fifo_idx_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q] & out_valid;
  assign pop       = out_valid & out_ready;

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDrain) & pop & out_last;
  assign err       = err_q;
  assign rd_addr_0 = addr0_q;
  assign rd_addr_1 = addr1_q;

  assign fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);

  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    addr0_d     = addr0_q;
    addr1_d     = addr1_q;
    issue_idx_d = issue_idx_q;
    push_idx_d  = push ? push_idx_q + 1'b1 : push_idx_q;
    err_d       = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (too_big) begin
            err_d = 1'b1;
          end else begin
            o_d         = shift[OW-1:0];
            addr0_d     = start_k;
            addr1_d     = wrap_inc(start_k);
            issue_idx_d = '0;
            push_idx_d  = '0;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        // Reads in flight are counted so the FIFO can never be overrun.
        if ((fifo_cnt_q + 3'(inflight_q)) < 3'd4) begin
          issue       = 1'b1;
          addr0_d     = wrap_inc(addr0_q);
          addr1_d     = wrap_inc(addr1_q);
          issue_idx_d = issue_idx_q + 1'b1;
          if (issue_idx_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      o_q         <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      issue_idx_q <= '0;
      push_idx_q  <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      issue_idx_q <= issue_idx_d;
      push_idx_q  <= push_idx_d;
      inflight_q  <= issue;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_idx_q[wr_ptr_q]  <= push_idx_q;
        fifo_last_q[wr_ptr_q] <= (push_idx_q == LastIdx);
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_rotate_reader.sv
// Bench for mem_rotate_reader: a small 8x4 instance with hand-computed vectors and a
// 512x70 instance against a bitwise rotate model.
module tb_mem_rotate_reader;

  localparam int BD = 70;
  localparam int BW = 512;
  localparam int BTOT = BD * BW;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Small instance; shift is one bit wider so out-of-range amounts can be driven.
  logic       s_start = 1'b0, s_busy, s_done, s_err, s_ol, s_ov, s_ordy = 1'b1;
  logic [5:0] s_shift = '0;
  logic [1:0] s_ra0, s_ra1, s_oi;
  logic [7:0] s_rd0, s_rd1, s_od;
  logic [7:0] s_mem [4] = '{default: '0};
  logic       s_wren = 1'b0;
  logic [1:0] s_waddr = '0;
  logic [7:0] s_wdata = '0;
  int         s_wviol = 0;

  logic         b_start = 1'b0, b_busy, b_done, b_err, b_ol, b_ov, b_ordy = 1'b1;
  logic [15:0]  b_shift = '0;
  logic [6:0]   b_ra0, b_ra1, b_oi;
  logic [511:0] b_rd0, b_rd1, b_od;
  logic [511:0] b_mem [BD] = '{default: '0};
  logic [511:0] ref_mem [BD];
  logic         b_wren = 1'b0;
  logic [6:0]   b_waddr = '0;
  logic [511:0] b_wdata = '0;
  int           b_wviol = 0;

  mem_rotate_reader #(.WIDTH(8), .DEPTH(4), .SHIFT_W(6)) u_s (
    .clock(clock), .reset_n(reset_n), .start(s_start), .shift(s_shift), .busy(s_busy),
    .done(s_done), .err(s_err), .rd_addr_0(s_ra0), .rd_addr_1(s_ra1), .rd_data_0(s_rd0),
    .rd_data_1(s_rd1), .out_data(s_od), .out_index(s_oi), .out_last(s_ol), .out_valid(s_ov),
    .out_ready(s_ordy)
  );

  mem_rotate_reader #(.WIDTH(BW), .DEPTH(BD)) u_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .shift(b_shift), .busy(b_busy),
    .done(b_done), .err(b_err), .rd_addr_0(b_ra0), .rd_addr_1(b_ra1), .rd_data_0(b_rd0),
    .rd_data_1(b_rd1), .out_data(b_od), .out_index(b_oi), .out_last(b_ol), .out_valid(b_ov),
    .out_ready(b_ordy)
  );

  // 2r1w memories; port 0 returns the write data on a write cycle.
  always @(posedge clock) begin
    s_rd0 <= s_wren ? s_wdata : s_mem[s_ra0];
    s_rd1 <= s_mem[s_ra1];
    if (s_wren) s_mem[s_waddr] <= s_wdata;
    if (s_wren && s_busy) s_wviol <= s_wviol + 1;
    b_rd0 <= b_wren ? b_wdata : b_mem[b_ra0];
    b_rd1 <= b_mem[b_ra1];
    if (b_wren) b_mem[b_waddr] <= b_wdata;
    if (b_wren && b_busy) b_wviol <= b_wviol + 1;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  s;
    bit          rnd;
    int          restart_at;
    logic [31:0] exp;  // {w3, w2, w1, w0}
  } vec_t;

  logic [7:0] got_w [4];
  int got_n, first_lat, done_cnt, done_bad, stall_bad, order_bad, max_occ;

  task automatic run_small(input logic [5:0] s, input bit rnd, input int restart_at);
    bit         prev_stall = 0;
    logic [7:0] prev_d = '0;
    logic [1:0] prev_i = '0;
    logic       prev_l = 1'b0;
    int         extra = 0;
    int         occ;
    got_n = 0; first_lat = -1; done_cnt = 0; done_bad = 0; stall_bad = 0; order_bad = 0;
    max_occ = 0;
    for (int i = 0; i < 4; i++) got_w[i] = 'x;
    @(negedge clock);
    s_start = 1'b1;
    s_shift = s;
    @(posedge clock);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      s_start = (n == restart_at);
      if (n == restart_at) s_shift = 6'd9;
      s_ordy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      occ = int'(u_s.fifo_cnt_q) + int'(u_s.inflight_q);
      if (occ > max_occ) max_occ = occ;
      if (prev_stall && (!s_ov || s_od !== prev_d || s_oi !== prev_i || s_ol !== prev_l))
        stall_bad++;
      if (s_ov && first_lat < 0) first_lat = n - 1;
      if (s_done !== (s_ov && s_ordy && s_ol)) done_bad++;
      if (s_ov && s_ordy) begin
        if (got_n < 4) begin
          got_w[got_n] = s_od;
          if (s_oi !== 2'(got_n) || s_ol !== (got_n == 3)) order_bad++;
        end
        got_n++;
        if (s_done) done_cnt++;
      end
      prev_stall = s_ov && !s_ordy;
      prev_d = s_od; prev_i = s_oi; prev_l = s_ol;
      if (got_n >= 4) extra++;
      if (extra > 4) break;
    end
    s_start = 1'b0;
    s_ordy  = 1'b1;
  endtask

  function automatic logic [511:0] ref_word(input int j, input int s);
    logic [511:0] r;
    int i;
    for (int b = 0; b < BW; b++) begin
      i = (j * BW + b + s) % BTOT;
      r[b] = ref_mem[i / BW][i % BW];
    end
    return r;
  endfunction

  task automatic run_big(input int s, input bit rnd);
    int seq = 0;
    int bad = 0;
    bit fin = 0;
    @(negedge clock);
    b_start = 1'b1;
    b_shift = 16'(s);
    @(posedge clock);
    for (int n = 1; n <= 400 && !fin; n++) begin
      @(negedge clock);
      b_start = 1'b0;
      b_ordy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      if (b_ov && b_ordy) begin
        if (b_oi !== 7'(seq) || b_ol !== (seq == BD - 1) || b_od !== ref_word(seq, s)) bad++;
        if (b_done) fin = 1;
        seq++;
      end
    end
    if (!fin || seq != BD) bad++;
    b_ordy = 1'b1;
    check($sformatf("big_run s=%0d", s), 512'(bad), 512'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{s: 6'd0,  rnd: 1'b0, restart_at: 0, exp: 32'h80_00_00_01};
    vecs[1] = '{s: 6'd1,  rnd: 1'b0, restart_at: 0, exp: 32'hC0_00_00_00};
    vecs[2] = '{s: 6'd28, rnd: 1'b0, restart_at: 0, exp: 32'h00_00_00_18};
    vecs[3] = '{s: 6'd31, rnd: 1'b0, restart_at: 0, exp: 32'h00_00_00_03};
    vecs[4] = '{s: 6'd5,  rnd: 1'b1, restart_at: 0, exp: 32'h0C_00_00_00};
    vecs[5] = '{s: 6'd5,  rnd: 1'b0, restart_at: 2, exp: 32'h0C_00_00_00};
    vecs[6] = '{s: 6'd16, rnd: 1'b0, restart_at: 0, exp: 32'h00_01_80_00};
    vecs[7] = '{s: 6'd8,  rnd: 1'b1, restart_at: 0, exp: 32'h01_80_00_00};

    #1;
    check("reset_outputs", 512'({s_busy, s_done, s_err, s_ov, s_ol, s_od, s_oi, s_ra0, s_ra1}),
          512'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s_wren = 1'b1;
      s_waddr = 2'(i);
      s_wdata = (i == 0) ? 8'h01 : (i == 3) ? 8'h80 : 8'h00;
    end
    @(negedge clock);
    s_wren = 1'b0;

    foreach (vecs[v]) begin
      run_small(vecs[v].s, vecs[v].rnd, vecs[v].restart_at);
      for (int w = 0; w < 4; w++)
        check($sformatf("v%0d_word%0d", v, w), 512'(got_w[w]), 512'(vecs[v].exp[w*8 +: 8]));
      check($sformatf("v%0d_count", v), 512'(got_n), 512'd4);
      check($sformatf("v%0d_order", v), 512'(order_bad), 512'd0);
      check($sformatf("v%0d_done", v), 512'(done_cnt * 16 + done_bad), 512'd16);
      check($sformatf("v%0d_stall_hold", v), 512'(stall_bad), 512'd0);
      check($sformatf("v%0d_occupancy_le4", v), 512'(max_occ > 4), 512'd0);
      check($sformatf("v%0d_idle_after", v), 512'(s_busy), 512'd0);
      if (!vecs[v].rnd && vecs[v].restart_at == 0)
        check($sformatf("v%0d_latency", v), 512'(first_lat), 512'd2);
    end

    // Out-of-range shift: err pulse only.
    @(negedge clock);
    s_start = 1'b1;
    s_shift = 6'd32;
    @(posedge clock);
    @(negedge clock);
    s_start = 1'b0;
    #1;
    check("err_pulse", 512'({s_err, s_busy}), 512'b10);
    @(negedge clock);
    #1;
    check("err_one_cycle", 512'({s_err, s_busy}), 512'b00);
    repeat (3) @(negedge clock);
    #1;
    check("err_no_output", 512'(s_ov), 512'd0);

    // Reset mid-stream.
    @(negedge clock);
    s_start = 1'b1;
    s_shift = 6'd0;
    s_ordy = 1'b0;
    @(posedge clock);
    @(negedge clock);
    s_start = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("pre_reset_valid", 512'({s_busy, s_ov}), 512'b11);
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          512'({s_busy, s_done, s_err, s_ov, s_ol, s_od, s_oi, s_ra0, s_ra1}), 512'd0);
    @(negedge clock);
    reset_n = 1'b1;
    s_ordy = 1'b1;
    run_small(6'd0, 1'b0, 0);
    check("post_reset_words", 512'({got_w[3], got_w[2], got_w[1], got_w[0]}),
          512'(32'h80_00_00_01));
    check("post_reset_count", 512'(got_n), 512'd4);

    // Large instance against the bitwise model.
    for (int i = 0; i < BD; i++) begin
      @(negedge clock);
      for (int k = 0; k < 16; k++) b_wdata[k*32 +: 32] = $urandom;
      ref_mem[i] = b_wdata;
      b_wren = 1'b1;
      b_waddr = 7'(i);
    end
    @(negedge clock);
    b_wren = 1'b0;

    run_big(0, 1'b0);
    run_big(BTOT - 1, 1'b1);
    run_big(BW, 1'b0);
    for (int r = 0; r < 197; r++) run_big(int'($urandom_range(BTOT - 1, 0)), (r % 4) == 0);

    @(negedge clock);
    b_start = 1'b1;
    b_shift = 16'(BTOT);
    @(posedge clock);
    @(negedge clock);
    b_start = 1'b0;
    #1;
    check("big_err_pulse", 512'({b_err, b_busy}), 512'b10);

    check("small_wren_while_busy", 512'(s_wviol), 512'd0);
    check("big_wren_while_busy", 512'(b_wviol), 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
